// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: parses 3-byte ASCII motor frames (letter, digit, terminator) from the UART.
// Drives registered motor direction and speed, with a link-loss watchdog that stops the cart.
// Define CMD_LOWERCASE_EN to also accept lowercase f/b/l/r/s as command letters.
module bt_cmd_decoder #(
    parameter int SPEED_STEP     = 28,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       left_dir,
    output logic       right_dir,
    output logic [7:0] left_speed,
    output logic [7:0] right_speed,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GOT_CMD = 2'd1;
    localparam logic [1:0] GOT_SPD = 2'd2;
    localparam logic [7:0] CH_F = 8'h46;
    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_S = 8'h53;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [3:0]    digit_q, digit_d;
    logic          left_dir_q, left_dir_d, right_dir_q, right_dir_d;
    logic [7:0]    left_speed_q, left_speed_d, right_speed_q, right_speed_d;
    logic          cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [7:0]    ucase, spd;
    logic          is_cmd, is_digit, is_term, commit, expire;

    // Byte classification; lowercase letters are folded to uppercase only when enabled
    always_comb begin
`ifdef CMD_LOWERCASE_EN
        ucase = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? (rx_data & 8'hDF) : rx_data;
`else
        ucase = rx_data;
`endif
        is_cmd   = ucase == CH_F || ucase == CH_B || ucase == CH_L || ucase == CH_R || ucase == CH_S;
        is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
        is_term  = rx_data == 8'h0A || rx_data == 8'h0D;
    end

    // Frame parser: a stray letter always resyncs onto a new frame
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        digit_d     = digit_q;
        commit      = 1'b0;
        frame_err_d = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_cmd) begin
                        cmd_d   = ucase;
                        state_d = GOT_CMD;
                    end else begin
                        frame_err_d = !is_term;
                    end
                end
                GOT_CMD: begin
                    if (is_digit) begin
                        digit_d = rx_data[3:0];
                        state_d = GOT_SPD;
                    end else begin
                        frame_err_d = 1'b1;
                        cmd_d       = is_cmd ? ucase : cmd_q;
                        state_d     = is_cmd ? GOT_CMD : IDLE;
                    end
                end
                GOT_SPD: begin
                    if (is_term) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        cmd_d       = is_cmd ? ucase : cmd_q;
                        state_d     = is_cmd ? GOT_CMD : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Motor outputs and watchdog; a commit on the expiry cycle takes priority over the stop
    always_comb begin
        spd           = 8'(SPEED_STEP) * {4'd0, digit_q};
        expire        = !timeout_q && wd_cnt_q == CW'(TIMEOUT_CYCLES - 1) && !commit;
        cmd_valid_d   = commit;
        timeout_d     = commit ? 1'b0 : (expire | timeout_q);
        wd_cnt_d      = commit ? '0 : (timeout_q || expire) ? wd_cnt_q : wd_cnt_q + 1'b1;
        left_dir_d    = left_dir_q;
        right_dir_d   = right_dir_q;
        left_speed_d  = left_speed_q;
        right_speed_d = right_speed_q;
        if (commit) begin
            left_dir_d    = !(cmd_q == CH_B || cmd_q == CH_L);
            right_dir_d   = !(cmd_q == CH_B || cmd_q == CH_R);
            left_speed_d  = cmd_q == CH_S ? 8'd0 : spd;
            right_speed_d = cmd_q == CH_S ? 8'd0 : spd;
        end else if (expire) begin
            left_dir_d    = 1'b1;
            right_dir_d   = 1'b1;
            left_speed_d  = 8'd0;
            right_speed_d = 8'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            digit_q       <= '0;
            left_dir_q    <= 1'b1;
            right_dir_q   <= 1'b1;
            left_speed_q  <= '0;
            right_speed_q <= '0;
            cmd_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            digit_q       <= digit_d;
            left_dir_q    <= left_dir_d;
            right_dir_q   <= right_dir_d;
            left_speed_q  <= left_speed_d;
            right_speed_q <= right_speed_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_err_q   <= frame_err_d;
            timeout_q     <= timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign left_dir    = left_dir_q;
    assign right_dir   = right_dir_q;
    assign left_speed  = left_speed_q;
    assign right_speed = right_speed_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_err   = frame_err_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb_bt_cmd_decoder: scoreboard bench for bt_cmd_decoder with a 1000-cycle watchdog.
module tb_bt_cmd_decoder;
    typedef struct packed {
        logic       ld;
        logic       rd;
        logic [7:0] ls;
        logic [7:0] rs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       left_dir, right_dir, cmd_valid, frame_err, timeout;
    logic [7:0] left_speed, right_speed;

    int   n_vec = 0;
    int   n_err = 0;
    int   fe_cnt = 0;
    exp_t sb[$];

    bt_cmd_decoder #(.SPEED_STEP(28), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .left_dir(left_dir), .right_dir(right_dir),
        .left_speed(left_speed), .right_speed(right_speed),
        .cmd_valid(cmd_valid), .frame_err(frame_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: every commit pulse is matched against the oldest expected frame
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (cmd_valid || frame_err) begin
            n_vec++;
            if (cmd_valid && frame_err) begin
                n_err++;
                $display("FAIL cv_fe_overlap: both cmd_valid and frame_err high at %0t", $time);
            end
        end
        if (cmd_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_commit: got dirs %b%b speeds %0d/%0d, required no commit",
                         left_dir, right_dir, left_speed, right_speed);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (left_dir !== e.ld || right_dir !== e.rd || left_speed !== e.ls || right_speed !== e.rs) begin
                    n_err++;
                    $display("FAIL commit_outputs: got dirs %b%b speeds %0d/%0d, required dirs %b%b speeds %0d/%0d",
                             left_dir, right_dir, left_speed, right_speed, e.ld, e.rd, e.ls, e.rs);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({left_dir, right_dir, left_speed, right_speed, cmd_valid, frame_err, timeout} !== {2'b11, 16'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_values: got dirs %b%b speeds %0d/%0d cv %b fe %b to %b, required dirs 11 speeds 0/0 cv 0 fe 0 to 0",
                     left_dir, right_dir, left_speed, right_speed, cmd_valid, frame_err, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_forward;
        int fe0 = fe_cnt;
        sb.push_back('{1'b1, 1'b1, 8'd140, 8'd140});
        send_byte("F");
        send_byte("5");
        send_byte(8'h0A);
        n_vec++;
        if (cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_latency: cmd_valid %b one cycle after terminator, required 1", cmd_valid);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_pulse_width: cmd_valid %b second cycle, required 0", cmd_valid);
        end
        n_vec++;
        if (left_speed !== 8'd140 || right_speed !== 8'd140) begin
            n_err++;
            $display("FAIL fwd_hold: speeds %0d/%0d, required 140/140", left_speed, right_speed);
        end
        n_vec++;
        if (fe_cnt - fe0 !== 0) begin
            n_err++;
            $display("FAIL fwd_no_err: %0d frame errors, required 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_crlf;
        int fe0 = fe_cnt;
        sb.push_back('{1'b0, 1'b1, 8'd252, 8'd252});
        send_byte("L");
        send_byte("9");
        send_byte(8'h0D);
        send_byte(8'h0A);
        @(posedge clk);
        #1;
        n_vec++;
        if (fe_cnt - fe0 !== 0) begin
            n_err++;
            $display("FAIL crlf_no_err: %0d frame errors, required 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_bad_byte;
        int fe0 = fe_cnt;
        send_byte("F");
        send_byte("X");
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL bad_byte_err: frame_err %b after X, required 1", frame_err);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({left_dir, right_dir, left_speed, right_speed} !== {2'b01, 8'd252, 8'd252} || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL bad_byte_hold: dirs %b%b speeds %0d/%0d fe %b, required dirs 01 speeds 252/252 fe 0",
                     left_dir, right_dir, left_speed, right_speed, frame_err);
        end
        sb.push_back('{1'b0, 1'b0, 8'd56, 8'd56});
        send_byte("B");
        send_byte("2");
        send_byte(8'h0A);
        @(posedge clk);
        #1;
        n_vec++;
        if (fe_cnt - fe0 !== 1) begin
            n_err++;
            $display("FAIL bad_byte_count: %0d frame errors, required 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_resync;
        int fe0 = fe_cnt;
        sb.push_back('{1'b1, 1'b0, 8'd84, 8'd84});
        send_byte("R");
        send_byte("R");
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL resync_err: frame_err %b after second R, required 1", frame_err);
        end
        send_byte("3");
        send_byte(8'h0A);
        @(posedge clk);
        #1;
        n_vec++;
        if (fe_cnt - fe0 !== 1) begin
            n_err++;
            $display("FAIL resync_count: %0d frame errors, required 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_stop_and_case;
        int fe0 = fe_cnt;
        sb.push_back('{1'b1, 1'b1, 8'd0, 8'd0});
        send_byte("S");
        send_byte("7");
        send_byte(8'h0A);
        sb.push_back('{1'b1, 1'b1, 8'd252, 8'd252});
        send_byte("F");
        send_byte("9");
        send_byte(8'h0D);
`ifdef CMD_LOWERCASE_EN
        sb.push_back('{1'b0, 1'b0, 8'd84, 8'd84});
`endif
        send_byte("b");
        send_byte("3");
        send_byte(8'h0A);
        @(posedge clk);
        #1;
        n_vec++;
`ifdef CMD_LOWERCASE_EN
        if (fe_cnt - fe0 !== 0) begin
            n_err++;
            $display("FAIL lowercase_count: %0d frame errors, required 0", fe_cnt - fe0);
        end
`else
        if (fe_cnt - fe0 !== 2) begin
            n_err++;
            $display("FAIL lowercase_count: %0d frame errors, required 2", fe_cnt - fe0);
        end
`endif
    endtask

    task automatic test_timeout_race;
        sb.push_back('{1'b1, 1'b1, 8'd196, 8'd196});
        send_byte("F");
        send_byte("7");
        send_byte(8'h0A);
        sb.push_back('{1'b1, 1'b1, 8'd28, 8'd28});
        send_byte("F");
        send_byte("1");
        repeat (997) @(posedge clk);
        send_byte(8'h0A);
        n_vec++;
        if (timeout !== 1'b0 || cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL race_commit_wins: timeout %b cv %b, required timeout 0 cv 1", timeout, cmd_valid);
        end
    endtask

    task automatic test_timeout;
        int rise = -1;
        sb.push_back('{1'b1, 1'b1, 8'd196, 8'd196});
        send_byte("F");
        send_byte("7");
        send_byte(8'h0A);
        for (int k = 1; k <= 1100 && rise < 0; k++) begin
            @(posedge clk);
            #1;
            if (timeout === 1'b1) rise = k;
        end
        n_vec++;
        if (rise !== 1000) begin
            n_err++;
            $display("FAIL timeout_latency: timeout rose %0d cycles after commit, required 1000", rise);
        end
        n_vec++;
        if ({left_dir, right_dir, left_speed, right_speed} !== {2'b11, 16'd0}) begin
            n_err++;
            $display("FAIL timeout_stop: dirs %b%b speeds %0d/%0d, required dirs 11 speeds 0/0",
                     left_dir, right_dir, left_speed, right_speed);
        end
        repeat (20) @(posedge clk);
        sb.push_back('{1'b1, 1'b1, 8'd28, 8'd28});
        send_byte("F");
        send_byte("1");
        send_byte(8'h0A);
        n_vec++;
        if (timeout !== 1'b0 || left_speed !== 8'd28) begin
            n_err++;
            $display("FAIL timeout_recover: timeout %b speed %0d, required timeout 0 speed 28", timeout, left_speed);
        end
    endtask

    task automatic test_reset_midframe;
        int fe0;
        send_byte("F");
        send_byte("4");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({left_dir, right_dir, left_speed, right_speed, timeout} !== {2'b11, 16'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midframe_reset: dirs %b%b speeds %0d/%0d to %b, required dirs 11 speeds 0/0 to 0",
                     left_dir, right_dir, left_speed, right_speed, timeout);
        end
        fe0 = fe_cnt;
        send_byte(8'h0A);
        n_vec++;
        if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_term: cv %b fe %b, required 0 0", cmd_valid, frame_err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (fe_cnt - fe0 !== 0 || left_speed !== 8'd0) begin
            n_err++;
            $display("FAIL midframe_quiet: %0d errors speed %0d, required 0 errors speed 0", fe_cnt - fe0, left_speed);
        end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_crlf;
        test_bad_byte;
        test_resync;
        test_stop_and_case;
        test_timeout_race;
        test_timeout;
        test_reset_midframe;
        repeat (2) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_commits: %0d expected frames never committed, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL sim_time_limit: bench did not finish within 1 ms");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/bt_cmd_decoder.md
Name: bt_cmd_decoder

Overview:
Downstream consumer of the Bluetooth UART receiver in the cart. It takes received bytes plus a one-cycle valid strobe and parses 3-byte ASCII command frames (command letter, speed digit, terminator). It drives registered left/right motor direction and speed to the PWM/motor-driver stage. A link-loss watchdog forces the cart to stop when no valid frame arrives within a timeout.

Parameters:
SPEED_STEP, 28, speed units per ASCII digit; speed = digit*SPEED_STEP; 9*SPEED_STEP must be <= 255
TIMEOUT_CYCLES, 100_000_000, clk cycles without a committed frame before forced stop (1 s at 100 MHz)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous, active-high reset
rx_data  input  8  received byte; sampled only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte from the UART receiver wrapper
left_dir  output  1  1=forward, 0=reverse
right_dir  output  1  1=forward, 0=reverse
left_speed  output  8  left motor duty value
right_speed  output  8  right motor duty value
cmd_valid  output  1  one-cycle pulse when a frame is committed
frame_err  output  1  one-cycle pulse on a malformed frame
timeout  output  1  level; 1 while the watchdog stop is in force

Behaviour:
- Reset (rst=1 at posedge): state IDLE, left_dir=right_dir=1, speeds=0, cmd_valid=0, frame_err=0, timeout=0, watchdog counter=0, latched cmd/digit cleared.
- Bytes are consumed only on cycles with rx_valid=1. Other cycles leave FSM state unchanged.
- Command letters: 'F'(0x46), 'B'(0x42), 'L'(0x4C), 'R'(0x52), 'S'(0x53). Digit: '0'..'9' (0x30..0x39). Terminator: 0x0A or 0x0D.
- FSM:
  - IDLE: command letter -> latch cmd, go GOT_CMD. Terminator -> ignored silently, stay IDLE (allows CRLF). Any other byte -> frame_err pulse, stay IDLE.
  - GOT_CMD: digit -> latch digit, go GOT_SPD. Command letter -> frame_err pulse, latch the new cmd, stay GOT_CMD (resync). Other byte -> frame_err pulse, go IDLE.
  - GOT_SPD: terminator -> commit, go IDLE. Command letter -> frame_err pulse, latch cmd, go GOT_CMD. Other byte -> frame_err pulse, go IDLE.
- Commit: outputs update on the clock edge after the terminator strobe cycle. cmd_valid=1 for exactly that one cycle. s = digit*SPEED_STEP (8-bit, no overflow given the parameter constraint).
  - F: both dirs=1, both speeds=s.
  - B: both dirs=0, both speeds=s.
  - L: left_dir=0, right_dir=1, both speeds=s (spin left).
  - R: left_dir=1, right_dir=0, both speeds=s.
  - S: both dirs=1, both speeds=0; the digit is required but ignored.
- Outputs hold their values between commits. frame_err and cmd_valid are never high in the same cycle.
- Watchdog:
  - Counter increments every cycle while timeout=0 and clears on commit.
  - When counter reaches TIMEOUT_CYCLES-1 without a commit, on the next edge timeout=1, speeds=0, dirs=1, and the counter holds.
  - The next commit clears timeout and applies that frame normally.
  - A commit in the same cycle as expiry wins: no timeout.
- Parsing continues normally while timeout=1.
- rst mid-frame: partial frame is discarded and all reset values are applied.

Optional Feature:
CMD_LOWERCASE_EN: when defined, lowercase 'f','b','l','r','s' are accepted as equivalent to the uppercase letters in every state. When undefined, lowercase letters are treated as invalid bytes (frame_err, per the FSM rules above).

Test Plan:
- Reset, then send 'F','5',0x0A -> one cycle after the 0x0A strobe: cmd_valid pulse; left/right_dir=1; left/right_speed=140.
- Send 'L','9',0x0D then 0x0A -> left_dir=0, right_dir=1, speeds=252; trailing 0x0A produces no frame_err.
- Send 'F','X' -> frame_err pulse on the 'X' byte, state IDLE, outputs unchanged. Then send 'B','2',0x0A -> both dirs=0, speeds=56.
- Send 'R','R','3',0x0A -> one frame_err pulse on the second 'R', then commit with left_dir=1, right_dir=0, speeds=84.
- TIMEOUT_CYCLES=1000: commit 'F','7',0x0A, then stay idle -> timeout=1 and speeds=0 exactly 1000 cycles after the commit. Then 'F','1',0x0A -> timeout=0, speeds=28.
- Assert rst after 'F','4' -> outputs at reset values. A following 0x0A is ignored (no commit, no error).
